// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t    : loader FSM state encoding (3-bit)
//   WORD_BYTES : bytes per instruction word
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects a byte stream into 32-bit little-endian words.
// Ports:
//   clk_i        system clock
//   rst_n        synchronous reset, active high
//   clear_i      discard any partially assembled word
//   byte_valid_i a byte is accepted this cycle
//   byte_i       accepted byte
//   word_o       registered word (stable until the next accepted byte)
//   word_next_o  word as it will look after this cycle's byte
//   word_valid_o this cycle's byte completes a word
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [31:0] word_next_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // Shifting in from the top leaves the first byte of a group in [7:0]
    // once all four have arrived.
    assign word_next_o  = {byte_i, word_q[31:8]};
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == LAST_BYTE);
    assign word_o       = word_q;

    always_ff @(posedge clk_i) begin
        if (rst_n || clear_i) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_next_o;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM writer: takes a program image as a byte stream
// (4-byte little-endian word count, then that many words) and writes it
// into instruction memory, holding the CPU while the load runs.
// Ports:
//   clk_i        system clock
//   rst_n        synchronous reset, active high
//   start_i      pulse to begin a load (ignored while busy)
//   rx_data_i    received byte
//   rx_valid_i   rx_data_i valid
//   rx_ready_o   loader accepts a byte this cycle
//   we_o         RAM write enable, one cycle per word
//   waddr_o      RAM byte address (word aligned)
//   wdata_o      RAM write data
//   cpu_hold_o   hold CPU/fetch while high
//   busy_o       load in progress
//   done_o       pulse on successful completion
//   err_o        error flag, held until the next start
//   words_o      words written in the current or last load
//
// state | meaning
// IDLE  | waiting for start
// HDR   | assembling the 32-bit word count
// DATA  | assembling the next data word
// WRITE | one-cycle RAM write of the assembled word
// DONE  | one-cycle completion pulse
// ERR   | oversize count or byte timeout; waits for a restart
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] words_o
);

    localparam logic [31:0] DEPTH_LIMIT  = 32'(DEPTH_WORDS);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] ADDR_STEP    = 32'(WORD_BYTES);

    state_t      state_q, state_d;
    logic        rx_ready_q;
    logic [31:0] waddr_q;
    logic [31:0] words_q;
    logic [31:0] remaining_q;
    logic [31:0] idle_tmr_q;

    logic        in_rx;
    logic        accept;
    logic        start_go;
    logic        timeout;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic [31:0] asm_next;

    assign in_rx    = (state_q == HDR) || (state_q == DATA);
    assign accept   = rx_valid_i && rx_ready_q;
    assign start_go = start_i && ((state_q == IDLE) || (state_q == ERR));
    // Idle timer counts down from TIMEOUT_CYCLES; the last idle cycle is
    // the one that sees it at 1. A zero load disables the check.
    assign timeout  = (TIMEOUT_LOAD != 32'd0) && in_rx && !accept
                      && (idle_tmr_q == 32'd1);

    imem_loader_byte_assembler u_asm (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .clear_i      (start_go || timeout),
        .byte_valid_i (accept),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_next_o  (asm_next),
        .word_valid_o (asm_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = HDR;
            end
            HDR: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (asm_valid) begin
                    if (asm_next == 32'd0)            state_d = DONE;
                    else if (asm_next > DEPTH_LIMIT)  state_d = ERR;
                    else                              state_d = DATA;
                end
            end
            DATA: begin
                if (timeout)        state_d = ERR;
                else if (asm_valid) state_d = WRITE;
            end
            WRITE: begin
                state_d = (remaining_q == 32'd1) ? DONE : DATA;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (start_i) state_d = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_o       = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            HDR, DATA: busy_o = 1'b1;
            WRITE: begin
                busy_o = 1'b1;
                we_o   = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            ERR:     err_o = 1'b1;
            default: ;
        endcase
        cpu_hold_o = busy_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            rx_ready_q  <= 1'b0;
            waddr_q     <= BASE_ADDR;
            words_q     <= 32'd0;
            remaining_q <= 32'd0;
            idle_tmr_q  <= TIMEOUT_LOAD;
        end else begin
            // Registered ready follows the state the FSM is entering.
            rx_ready_q <= (state_d == HDR) || (state_d == DATA);

            if (start_go) begin
                waddr_q <= BASE_ADDR;
                words_q <= 32'd0;
            end else if (state_q == WRITE) begin
                waddr_q     <= waddr_q + ADDR_STEP;
                words_q     <= words_q + 32'd1;
                remaining_q <= remaining_q - 32'd1;
            end

            if ((state_q == HDR) && asm_valid) begin
                remaining_q <= asm_next;
            end

            if (!in_rx || accept) begin
                idle_tmr_q <= TIMEOUT_LOAD;
            end else if (idle_tmr_q != 32'd0) begin
                idle_tmr_q <= idle_tmr_q - 32'd1;
            end
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = asm_word;
    assign words_o    = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-RAM path. It receives a program image as a byte stream from the serial receiver and writes it into instruction memory as 32-bit words at word-aligned byte addresses.
- The fetch unit is the reader of the same RAM. While a load is in progress, the loader holds the CPU, so fetch sees a stable image from PC 0 once the hold is released.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH_WORDS, 16384, capacity of instruction RAM in 32-bit words.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes before abort. 0 disables the timeout.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1, despite the name).
- start_i  in  1  one-cycle pulse that begins a load.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  rx_data_i valid this cycle.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- we_o  out  1  instruction RAM write enable (one-cycle pulse per word).
- waddr_o  out  32  RAM byte address, always a multiple of 4.
- wdata_o  out  32  RAM write data.
- cpu_hold_o  out  1  hold CPU/fetch in reset while high.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky error flag.
- words_o  out  32  number of words written in the current or last load.

Behaviour:
- Reset: all outputs 0, waddr_o = BASE_ADDR, state IDLE. Reset during any state aborts the load immediately; no further writes are issued.
- Byte transfer: occurs when rx_valid_i and rx_ready_o are both high. rx_ready_o is registered, high only in HDR and DATA.
- Byte order: little-endian. The first accepted byte of a group lands in bits [7:0], the fourth in [31:24].
- State IDLE:
  - start_i -> HDR; clear byte count, words_o and err_o; set waddr_o = BASE_ADDR.
  - Bytes presented in IDLE are not accepted.
- State HDR: assemble 4 bytes into count N. After the 4th byte:
  - N == 0 -> DONE.
  - N > DEPTH_WORDS -> ERR.
  - Otherwise -> DATA with remaining = N.
- State DATA: assemble 4 bytes into wdata_o. The 4th byte is accepted in cycle t; WRITE is active in cycle t+1.
- State WRITE: exactly one cycle.
  - we_o = 1 with the current waddr_o and wdata_o; rx_ready_o = 0.
  - Next cycle: waddr_o += 4, words_o += 1, remaining -= 1.
  - If remaining was 1 -> DONE, else -> DATA.
- State DONE: done_o = 1 for one cycle, then IDLE.
- State ERR:
  - err_o = 1 and held; cpu_hold_o = 0; no writes.
  - start_i restarts the load: -> HDR, err_o cleared.
- Timeout: in HDR or DATA, an idle counter resets on every accepted byte. When it reaches TIMEOUT_CYCLES with no byte -> ERR. Any partially assembled word is discarded.
- busy_o and cpu_hold_o are 1 in HDR, DATA, WRITE and DONE; 0 in IDLE and ERR.
- start_i while busy_o = 1 is ignored.
- rx_valid_i in the same cycle as start_i (while IDLE) is not accepted.
- waddr_o wraps modulo 2^32. The DEPTH_WORDS check prevents overrun for any count that is in range.

Decomposition:
- Shared include file imem_loader_defs:
  - state encodings IDLE, HDR, DATA, WRITE, DONE, ERR (3-bit);
  - WORD_BYTES = 4.
- One natural sub-module, byte_assembler:
  - 2-bit byte counter plus 32-bit little-endian shift/insert register;
  - outputs word_o and a word_valid pulse;
  - clear input used on start, timeout and reset;
  - reused for both the header and data words.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 back-to-back.
  - Required: we_o at addr 0x0 data 0x00000013 and at addr 0x4 data 0x00100093; done_o pulses once; words_o = 2; cpu_hold_o falls after done.
- Zero-length header:
  - Stimulus: start, then bytes 00 00 00 00.
  - Required: no we_o; done_o pulses one cycle after the 4th byte; words_o = 0.
- Oversize count:
  - Stimulus: DEPTH_WORDS = 4, header 05 00 00 00.
  - Required: ERR, err_o = 1, no we_o, rx_ready_o = 0.
  - Follow-up: a new start_i clears err_o and a valid load succeeds.
- Gaps and timeout (TIMEOUT_CYCLES = 16):
  - Random idle gaps shorter than 16 cycles give the same writes as the normal load.
  - A stall of 16 cycles after 2 data bytes -> err_o = 1 and no write of the partial word.
- Reset mid-DATA:
  - Stimulus: assert rst_n after 1 written word and 2 bytes of the next.
  - Required: all outputs 0 next cycle; the partial word is never written; a following full load writes from BASE_ADDR.
- Protocol guards:
  - rx_valid_i asserted in IDLE gets no acceptance.
  - start_i pulsed during DATA does not alter waddr_o or words_o.
  - we_o is never high in two consecutive cycles.
